car_rpm_top: RTL and testbench

- Top level of the car RPM/gear dashboard on a 100 MHz FPGA board.
- Two push-buttons (accelerate/decelerate) change a 4-bit speed level; a 3-bit gear switch selects a per-gear maximum level.
- Drives an RPM LED bar plus a traffic-light RGB indicator, a servo gauge, a speed 7-segment display, a gear 7-segment digit and an over-rev piezo.

---
 rtl/car_rpm_top_pkg.sv | 51 +++++
 rtl/car_rpm_top_clk_div.sv | 33 +++
 rtl/car_rpm_top_rpm_ctrl.sv | 84 ++++++++
 rtl/car_rpm_top.sv | 131 +++++++++++++
 tb/tb_car_rpm_top.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/car_rpm_top_pkg.sv
// Shared definitions for the car RPM dashboard: gear limits, 7-segment glyphs
// and traffic-light colour codes.
package car_rpm_top_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_N     = 8'h2A;  // segments c, e, g

  localparam int         N_BTN     = 2;
  localparam logic [3:0] SPEED_MAX = 4'd15;

  // One-clock debounced press pulses from the two buttons.
  typedef struct packed {
    logic accel;
    logic decel;
  } press_t;

  // Highest speed level that is still "in range" for each gear; 7 aliases 6.
  function automatic logic [3:0] gear_max(input logic [2:0] gear);
    case (gear)
      3'd0:    return 4'd0;
      3'd1:    return 4'd3;
      3'd2:    return 4'd5;
      3'd3:    return 4'd8;
      3'd4:    return 4'd10;
      3'd5:    return 4'd12;
      default: return 4'd15;
    endcase
  endfunction

  // Decimal digit to segments {a,b,c,d,e,f,g,dp}; anything above 9 is blank.
  function automatic logic [7:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    return 8'hFC;
      4'd1:    return 8'h60;
      4'd2:    return 8'hDA;
      4'd3:    return 8'hF2;
      4'd4:    return 8'h66;
      4'd5:    return 8'hB6;
      4'd6:    return 8'hBE;
      4'd7:    return 8'hE0;
      4'd8:    return 8'hFE;
      4'd9:    return 8'hF6;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/car_rpm_top_clk_div.sv
// Divides the system clock into a 1 kHz square wave and a one-clock enable
// that fires on the cycle where that square wave rises.
module clk_div #(
  parameter int TICK_HALF = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_1khz,
  output logic tick
);

  localparam int CW = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(TICK_HALF - 1));
  assign tick = wrap & ~clk_1khz;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clk_1khz <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      clk_1khz <= ~clk_1khz;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/car_rpm_top_rpm_ctrl.sv
// Button debouncing, gear synchronisation and the saturating speed counter.
module rpm_ctrl
  import car_rpm_top_pkg::*;
#(
  parameter int DEB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_accel,
  input  logic       btn_decel,
  input  logic [2:0] gear_sw,
  output logic [3:0] speed_level,
  output logic [3:0] max_level,
  output logic [2:0] gear
);

  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  logic [N_BTN-1:0] btn_raw, sync1, sync2, deb, deb_q;
  logic [DW-1:0]    stable_cnt [N_BTN];
  logic [2:0]       gear_s1, gear_s2;
  press_t           press;

  assign btn_raw = {btn_decel, btn_accel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb_q   <= '0;
      gear_s1 <= '0;
      gear_s2 <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      deb_q   <= deb;
      gear_s1 <= gear_sw;
      gear_s2 <= gear_s1;
    end
  end

  // A level flips only after DEB_TICKS consecutive tick samples disagree with it.
  // NOTE: the per-button counter array is only two entries, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < N_BTN; i++) stable_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == deb[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == DW'(DEB_TICKS - 1)) begin
          deb[i]        <= sync2[i];
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press.accel = deb[0] & ~deb_q[0];
    press.decel = deb[1] & ~deb_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_level <= '0;
      max_level   <= '0;
      gear        <= '0;
    end else begin
      max_level <= gear_max(gear_s2);
      gear      <= (gear_s2 == 3'd7) ? 3'd6 : gear_s2;
      case ({press.accel, press.decel})
        2'b10:   if (speed_level != SPEED_MAX) speed_level <= speed_level + 1'b1;
        2'b01:   if (speed_level != 4'd0)      speed_level <= speed_level - 1'b1;
        default: speed_level <= speed_level;
      endcase
    end
  end

endmodule

// File: rtl/car_rpm_top.sv
// Car RPM/gear dashboard: LED bar and RGB light, servo gauge, speed and gear
// 7-segment displays and the over-rev buzzer.
module car_rpm_top
  import car_rpm_top_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HALF    = CLK_HZ / 2_000,
  parameter int DEB_TICKS    = 4,
  parameter int SERVO_PERIOD = 2_000_000,
  parameter int SERVO_MIN    = 100_000,
  parameter int SERVO_STEP   = 6_667
) (
  input  logic       clk_100mhz,
  input  logic       rst_btn,
  input  logic       btn_accel,
  input  logic       btn_decel,
  input  logic [2:0] gear_sw,
  output logic       servo_pwm,
  output logic [7:0] speed_fnd_sel,
  output logic [7:0] speed_fnd_seg,
  output logic [7:0] gear_seg,
  output logic [7:0] leds,
  output logic       piezo
);

  localparam int SW = $clog2(SERVO_PERIOD + 1);

  logic          clk_1khz, tick;
  logic [3:0]    speed_level, max_level;
  logic [2:0]    gear;
  logic [2:0]    rgb;
  logic [4:0]    bar;
  logic [6:0]    x, m7;
  logic          over_rev;
  logic [SW-1:0] servo_cnt, servo_hi;
  logic [2:0]    scan_idx;
  logic [3:0]    ones, tens;
  logic [7:0]    digit_seg;

  clk_div #(.TICK_HALF(TICK_HALF)) u_clk_div (
    .clk      (clk_100mhz),
    .rst_n    (rst_btn),
    .clk_1khz (clk_1khz),
    .tick     (tick)
  );

  rpm_ctrl #(.DEB_TICKS(DEB_TICKS)) u_rpm_ctrl (
    .clk         (clk_100mhz),
    .rst_n       (rst_btn),
    .tick        (tick),
    .btn_accel   (btn_accel),
    .btn_decel   (btn_decel),
    .gear_sw     (gear_sw),
    .speed_level (speed_level),
    .max_level   (max_level),
    .gear        (gear)
  );

  // NOTE: defaults are assigned first so every path drives every output (no latch).
  always_comb begin
    rgb = GREEN;
    if (speed_level >= max_level)                 rgb = RED;
    else if (speed_level >= {1'b0, max_level[3:1]}) rgb = YELLOW;
  end

  // Bar segment k lights once 5*S reaches k*M, i.e. S/M has passed k/5.
  always_comb begin
    bar = '0;
    x   = 7'(speed_level) * 7'd5;
    m7  = 7'(max_level);
    if (max_level != 4'd0) begin
      bar[0] = (speed_level != 4'd0);
      bar[1] = (x >= m7);
      bar[2] = (x >= m7 * 7'd2);
      bar[3] = (x >= m7 * 7'd3);
      bar[4] = (x >= m7 * 7'd4);
    end
  end

  assign over_rev = (speed_level >= max_level) && (max_level != 4'd0);

  always_ff @(posedge clk_100mhz or negedge rst_btn) begin
    if (!rst_btn) begin
      leds     <= '0;
      piezo    <= 1'b0;
      gear_seg <= SEG_BLANK;
    end else begin
      leds     <= {rgb, bar};
      piezo    <= over_rev & clk_1khz;
      gear_seg <= (gear == 3'd0) ? SEG_N : seg7({1'b0, gear});
    end
  end

  assign servo_hi = SW'(SERVO_MIN) + SW'(speed_level) * SW'(SERVO_STEP);

  always_ff @(posedge clk_100mhz or negedge rst_btn) begin
    if (!rst_btn) begin
      servo_cnt <= '0;
      servo_pwm <= 1'b0;
    end else begin
      servo_cnt <= (servo_cnt == SW'(SERVO_PERIOD - 1)) ? '0 : servo_cnt + 1'b1;
      servo_pwm <= (servo_cnt < servo_hi);
    end
  end

  assign ones = speed_level % 4'd10;
  assign tens = speed_level / 4'd10;

  always_comb begin
    digit_seg = SEG_BLANK;
    case (scan_idx)
      3'd0:    digit_seg = seg7(ones);
      3'd1:    digit_seg = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
      default: digit_seg = SEG_BLANK;
    endcase
  end

  // Select and segments are registered together so they always describe the same digit.
  always_ff @(posedge clk_100mhz or negedge rst_btn) begin
    if (!rst_btn) begin
      scan_idx      <= '0;
      speed_fnd_sel <= 8'hFF;
      speed_fnd_seg <= SEG_BLANK;
    end else if (tick) begin
      scan_idx      <= scan_idx + 1'b1;
      speed_fnd_sel <= ~(8'd1 << scan_idx);
      speed_fnd_seg <= digit_seg;
    end
  end

endmodule

// File: tb/tb_car_rpm_top.sv
// Self-checking bench for car_rpm_top: a scripted vector table, hand-written
// servo/display/buzzer sequences and a randomized run against a speed model.
module tb_car_rpm_top;

  localparam int TICK_HALF    = 4;
  localparam int DEB_TICKS    = 4;
  localparam int SERVO_PERIOD = 2000;
  localparam int SERVO_MIN    = 100;
  localparam int SERVO_STEP   = 7;
  localparam int TICK_CLKS    = 2 * TICK_HALF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_accel = 1'b0;
  logic       btn_decel = 1'b0;
  logic [2:0] gear_sw = 3'd0;
  logic       servo_pwm, piezo;
  logic [7:0] speed_fnd_sel, speed_fnd_seg, gear_seg, leds;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  car_rpm_top #(
    .CLK_HZ       (100_000_000),
    .TICK_HALF    (TICK_HALF),
    .DEB_TICKS    (DEB_TICKS),
    .SERVO_PERIOD (SERVO_PERIOD),
    .SERVO_MIN    (SERVO_MIN),
    .SERVO_STEP   (SERVO_STEP)
  ) dut (
    .clk_100mhz    (clk),
    .rst_btn       (rst_n),
    .btn_accel     (btn_accel),
    .btn_decel     (btn_decel),
    .gear_sw       (gear_sw),
    .servo_pwm     (servo_pwm),
    .speed_fnd_sel (speed_fnd_sel),
    .speed_fnd_seg (speed_fnd_seg),
    .gear_seg      (gear_seg),
    .leds          (leds),
    .piezo         (piezo)
  );

  typedef struct {
    string      name;
    int         gear;
    int         n_acc;
    int         n_dec;
    int         n_both;
    int         speed;
    int         max;
    logic [7:0] leds;
    logic [7:0] gseg;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    wait_clks(n * TICK_CLKS);
  endtask

  task automatic press(input logic a, input logic d);
    btn_accel = a;
    btn_decel = d;
    wait_ticks(20);
    btn_accel = 1'b0;
    btn_decel = 1'b0;
    wait_ticks(5);
  endtask

  // Waits for a falling edge, then a rising edge, and counts the high clocks.
  task automatic measure_pwm(output int hi);
    int k;
    hi = 0;
    k  = 0;
    while (servo_pwm !== 1'b0 && k < SERVO_PERIOD + 10) begin k++; wait_clks(1); end
    k = 0;
    while (servo_pwm !== 1'b1 && k < SERVO_PERIOD + 10) begin k++; wait_clks(1); end
    while (servo_pwm === 1'b1 && hi < SERVO_PERIOD) begin hi++; wait_clks(1); end
  endtask

  task automatic piezo_seen(output logic seen);
    seen = 1'b0;
    repeat (2 * TICK_CLKS) begin
      @(negedge clk);
      if (piezo === 1'b1) seen = 1'b1;
    end
  endtask

  // Reference model, written directly from the dashboard rules.
  function automatic int model_max(input int g);
    int t[8] = '{0, 3, 5, 8, 10, 12, 15, 15};
    return t[g];
  endfunction

  function automatic logic [7:0] model_leds(input int s, input int m);
    logic [2:0] rgb;
    logic [4:0] bar;
    if (s >= m)          rgb = 3'b100;
    else if (s >= m / 2) rgb = 3'b110;
    else                 rgb = 3'b010;
    bar = '0;
    if (m != 0) begin
      bar[0] = (s > 0);
      for (int k = 1; k <= 4; k++) bar[k] = (5 * s >= k * m);
    end
    return {rgb, bar};
  endfunction

  function automatic logic [7:0] model_gseg(input int g);
    logic [7:0] t[7] = '{8'h2A, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE};
    return t[(g > 6) ? 6 : g];
  endfunction

  initial begin
    repeat (90_000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within the cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[14];
    int         hi;
    logic       saw_hi, saw_lo, seen;
    logic [7:0] fnd0, fnd1, fnd2;
    int         m_speed, m_gear, op;

    vecs[0]  = '{"idle_g1", 1, 0,  0,  0, 0,  3,  8'b010_00000, 8'h60};
    vecs[1]  = '{"g1_s1",   1, 1,  0,  0, 1,  3,  8'b110_00011, 8'h60};
    vecs[2]  = '{"g1_s2",   1, 1,  0,  0, 2,  3,  8'b110_01111, 8'h60};
    vecs[3]  = '{"g1_s3",   1, 1,  0,  0, 3,  3,  8'b100_11111, 8'h60};
    vecs[4]  = '{"g6_s3",   6, 0,  0,  0, 3,  15, 8'b010_00011, 8'hBE};
    vecs[5]  = '{"g6_s8",   6, 5,  0,  0, 8,  15, 8'b110_00111, 8'hBE};
    vecs[6]  = '{"g6_s15",  6, 7,  0,  0, 15, 15, 8'b100_11111, 8'hBE};
    vecs[7]  = '{"g6_s14",  6, 0,  1,  0, 14, 15, 8'b110_11111, 8'hBE};
    vecs[8]  = '{"both",    6, 0,  0,  1, 14, 15, 8'b110_11111, 8'hBE};
    vecs[9]  = '{"sat15",   6, 20, 0,  0, 15, 15, 8'b100_11111, 8'hBE};
    vecs[10] = '{"to0",     6, 0,  15, 0, 0,  15, 8'b010_00000, 8'hBE};
    vecs[11] = '{"sat0",    6, 0,  1,  0, 0,  15, 8'b010_00000, 8'hBE};
    vecs[12] = '{"g7",      7, 0,  0,  0, 0,  15, 8'b010_00000, 8'hBE};
    vecs[13] = '{"neutral", 0, 0,  0,  0, 0,  0,  8'b100_00000, 8'h2A};

    gear_sw = 3'd1;
    wait_clks(10);
    check("rst_clk_1khz", 32'(dut.u_clk_div.clk_1khz), 32'd0);
    check("rst_speed", 32'(dut.u_rpm_ctrl.speed_level), 32'd0);
    check("rst_servo_pwm", 32'(servo_pwm), 32'd0);
    check("rst_piezo", 32'(piezo), 32'd0);
    check("rst_fnd_sel", 32'(speed_fnd_sel), 32'hFF);
    check("rst_leds", 32'(leds), 32'd0);
    rst_n = 1'b1;
    wait_ticks(15);

    for (int i = 0; i < 14; i++) begin
      gear_sw = 3'(vecs[i].gear);
      wait_ticks(2);
      repeat (vecs[i].n_acc)  press(1'b1, 1'b0);
      repeat (vecs[i].n_dec)  press(1'b0, 1'b1);
      repeat (vecs[i].n_both) press(1'b1, 1'b1);
      wait_ticks(8);
      check({vecs[i].name, "_speed"}, 32'(dut.u_rpm_ctrl.speed_level), 32'(vecs[i].speed));
      check({vecs[i].name, "_max"}, 32'(dut.u_rpm_ctrl.max_level), 32'(vecs[i].max));
      check({vecs[i].name, "_leds"}, 32'(leds), 32'(vecs[i].leds));
      check({vecs[i].name, "_gear_seg"}, 32'(gear_seg), 32'(vecs[i].gseg));
      if (i == 3) begin
        saw_hi = 1'b0;
        saw_lo = 1'b0;
        repeat (4 * TICK_CLKS) begin
          @(negedge clk);
          if (piezo === 1'b1) saw_hi = 1'b1;
          if (piezo === 1'b0) saw_lo = 1'b0 | 1'b1;
        end
        check("piezo_toggle", 32'({saw_hi, saw_lo}), 32'b11);
      end
    end

    measure_pwm(hi);
    check("servo_hi_s0", 32'(hi), 32'(SERVO_MIN));

    repeat (16) press(1'b1, 1'b0);
    wait_ticks(8);
    check("s15_speed", 32'(dut.u_rpm_ctrl.speed_level), 32'd15);
    measure_pwm(hi);
    check("servo_hi_s15", 32'(hi), 32'(SERVO_MIN + 15 * SERVO_STEP));

    fnd0 = 8'hxx;
    fnd1 = 8'hxx;
    fnd2 = 8'hxx;
    repeat (20 * TICK_CLKS) begin
      @(negedge clk);
      if (speed_fnd_sel === 8'hFE) fnd0 = speed_fnd_seg;
      if (speed_fnd_sel === 8'hFD) fnd1 = speed_fnd_seg;
      if (speed_fnd_sel === 8'hFB) fnd2 = speed_fnd_seg;
    end
    check("fnd_digit0", 32'(fnd0), 32'hB6);
    check("fnd_digit1", 32'(fnd1), 32'h60);
    check("fnd_digit2", 32'(fnd2), 32'h00);

    piezo_seen(seen);
    check("neutral_piezo", 32'(seen), 32'd0);

    m_speed = 15;
    m_gear  = 0;
    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0, 3: begin
          press(1'b1, 1'b0);
          if (m_speed < 15) m_speed++;
        end
        1: begin
          press(1'b0, 1'b1);
          if (m_speed > 0) m_speed--;
        end
        2: press(1'b1, 1'b1);
        default: begin
          m_gear  = int'($urandom_range(0, 7));
          gear_sw = 3'(m_gear);
        end
      endcase
      wait_ticks(8);
      check($sformatf("rnd%0d_speed", n), 32'(dut.u_rpm_ctrl.speed_level), 32'(m_speed));
      check($sformatf("rnd%0d_max", n), 32'(dut.u_rpm_ctrl.max_level), 32'(model_max(m_gear)));
      check($sformatf("rnd%0d_leds", n), 32'(leds), 32'(model_leds(m_speed, model_max(m_gear))));
      check($sformatf("rnd%0d_gear_seg", n), 32'(gear_seg), 32'(model_gseg(m_gear)));
      piezo_seen(seen);
      check($sformatf("rnd%0d_piezo", n), 32'(seen),
            32'((m_speed >= model_max(m_gear)) && (model_max(m_gear) > 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
